// File: rtl/ram_dual_port_param_if.sv
// Bus bundle for ram_dual_port_param: one write port, one read port and status.
// The master drives requests; the slave (the RAM) returns read data and status.
interface ram_dual_port_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  re;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  read_valid;
  logic                  busy;

  modport master (
    output we, write_addr, data_in, re, read_addr,
    input  data_out, read_valid, busy
  );

  modport slave (
    input  we, write_addr, data_in, re, read_addr,
    output data_out, read_valid, busy
  );
endinterface

// File: rtl/ram_dual_port_param.sv
// Simple dual-port RAM (one write, one read port) with a zero-fill sweep after
// reset, selectable read-during-write behaviour and optional output register.
module ram_dual_port_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_dual_port_param_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit WRITE_THROUGH = (RDW_MODE != 0);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] sweep_ptr_q;
  logic                  ready;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rd_accept;
  logic                  rd_bypass;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_valid_q;

  assign ready = (state_q == ST_READY);

  // Sweep pointer walks every word once; the last word hands over to READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_ptr_q <= '0;
    end else if (state_q == ST_INIT) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      sweep_ptr_q <= sweep_ptr_q + 1'b1;
      if (sweep_ptr_q == '1) begin
        state_q <= ST_READY;
      end
    end
  end

  // Write-port mux: the sweep owns the array until READY, user writes after.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    mem_we    = 1'b0;
    mem_waddr = bus.write_addr;
    mem_wdata = bus.data_in;
    if (rst_n) begin
      if (!ready) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_ptr_q;
        mem_wdata = '0;
      end else begin
        mem_we    = bus.we;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM macros; the INIT sweep
  // is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // The array read at the edge returns the pre-write word; write-through
  // forwards data_in instead when both ports hit the same address.
  assign rd_accept = ready && bus.re;
  assign rd_bypass = WRITE_THROUGH && bus.we && (bus.write_addr == bus.read_addr);
  assign rd_word   = rd_bypass ? bus.data_in : mem[bus.read_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_data_q <= rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_valid_q;

      // Second stage holds its word when no read is in flight, like stage one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign bus.data_out   = s2_data_q;
      assign bus.read_valid = s2_valid_q;
    end else begin : g_no_out_reg
      assign bus.data_out   = s1_data_q;
      assign bus.read_valid = s1_valid_q;
    end
  endgenerate

  assign bus.busy = !ready;

endmodule

// File: tb/tb_ram_dual_port_param.sv
// Self-checking bench: four RAM instances covering both read-during-write modes
// and both output latencies, all driven by one stimulus stream and one model.
module tb_ram_dual_port_param;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int NDUT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout [NDUT];
  logic          rv   [NDUT];
  logic          bsy  [NDUT];

  int checks = 0;
  int errors = 0;

  // Instance k: write-through when k is odd, output register when k >= 2.
  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      ram_dual_port_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
      assign bus.we         = we;
      assign bus.write_addr = wa;
      assign bus.data_in    = din;
      assign bus.re         = re;
      assign bus.read_addr  = ra;
      assign dout[g]        = bus.data_out;
      assign rv[g]          = bus.read_valid;
      assign bsy[g]         = bus.busy;

      ram_dual_port_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(g % 2), .OUT_REG(g / 2)
      ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
      );
    end
  endgenerate

  // Reference model: word array, remaining init cycles, and the expected
  // output of each instance one and two cycles after a request.
  logic [DW-1:0] mem_m [DEPTH];
  int            init_left = DEPTH;
  logic [DW-1:0] lat1_d [NDUT];
  logic          lat1_v [NDUT];
  logic [DW-1:0] lat2_d [NDUT];
  logic          lat2_v [NDUT];

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      check("busy", k, 32'(bsy[k]), 32'(init_left > 0));
      check("read_valid", k, 32'(rv[k]), 32'((k / 2 == 1) ? lat2_v[k] : lat1_v[k]));
      check("data_out", k, 32'(dout[k]), 32'((k / 2 == 1) ? lat2_d[k] : lat1_d[k]));
    end
  endtask

  task automatic model_reset();
    init_left = DEPTH;
    for (int k = 0; k < NDUT; k++) begin
      lat1_d[k] = '0; lat1_v[k] = 1'b0;
      lat2_d[k] = '0; lat2_v[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] rd [NDUT];
    bit            rdy;
    rdy = (init_left == 0);
    if (!rdy) begin
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      rd[k] = ((k % 2 == 1) && we && (wa == ra)) ? din : mem_m[ra];
    end
    for (int k = 0; k < NDUT; k++) begin
      if (lat1_v[k]) lat2_d[k] = lat1_d[k];
      lat2_v[k] = lat1_v[k];
      lat1_v[k] = rdy && re;
      if (rdy && re) lat1_d[k] = rd[k];
    end
    if (rdy && we) mem_m[wa] = din;
  endtask

  task automatic step(bit w, logic [AW-1:0] a, logic [DW-1:0] d, bit r, logic [AW-1:0] b);
    @(negedge clk);
    we = w; wa = a; din = d; re = r; ra = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rand_step(int max_addr);
    step(1'($urandom), AW'($urandom_range(0, max_addr)), DW'($urandom),
         1'($urandom), AW'($urandom_range(0, max_addr)));
  endtask

  // Reset is asserted between edges so its effect must be asynchronous;
  // release also falls between edges so the model never misses a sweep edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, 1'b1, AW'(a));
    idle(2);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Init sweep with random traffic that must be ignored, incl. 0xFF -> 7.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5) step(1'b1, AW'(7), 8'hFF, 1'b1, AW'(7));
      else        rand_step(DEPTH - 1);
    end
    read_all();

    // Write then read back next cycle.
    step(1'b1, AW'(10), 8'hA5, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, AW'(10));
    idle(2);

    // Same-address write and read: old word vs write-through.
    step(1'b1, AW'(5), 8'h11, 1'b0, '0);
    step(1'b1, AW'(5), 8'h3C, 1'b1, AW'(5));
    idle(2);
    step(1'b0, '0, '0, 1'b1, AW'(5));
    idle(2);

    // Back-to-back reads of preloaded words.
    for (int a = 1; a <= 3; a++) step(1'b1, AW'(a), DW'(a), 1'b0, '0);
    for (int a = 1; a <= 3; a++) step(1'b0, '0, '0, 1'b1, AW'(a));
    idle(3);

    // Random traffic; a narrow address window forces frequent collisions.
    for (int i = 0; i < 300; i++) rand_step(7);
    for (int i = 0; i < 200; i++) rand_step(DEPTH - 1);

    // Reset with a read in flight.
    step(1'b1, AW'(3), 8'h5A, 1'b1, AW'(3));
    do_reset();

    // Reset again at sweep pointer 30 with both enables active.
    for (int i = 0; i < 30; i++) step(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom));
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom));
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
